// File: rtl/trap_sequencer_pkg.sv
// Shared types, CSR addresses and mstatus helpers for the trap sequencer.
package trap_sequencer_pkg;

  localparam int XLEN = 32;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [XLEN-1:0] M_TIMER_INT = 32'h8000_0007;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LSB  = 11;

  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    SAVE_EPC,
    SAVE_CAUSE,
    SAVE_TVAL,
    SET_STATUS,
    RESTORE_STATUS,
    REDIRECT
  } trap_state_t;

  // Trap entry: stash MIE in MPIE, mask interrupts, record machine mode as MPP.
  function automatic logic [XLEN-1:0] mstatus_trap_entry(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r = m;
    r[MSTATUS_MPIE_BIT] = m[MSTATUS_MIE_BIT];
    r[MSTATUS_MIE_BIT] = 1'b0;
    r[MSTATUS_MPP_LSB +: 2] = 2'b11;
    return r;
  endfunction

  // MRET: restore MIE from MPIE, set MPIE, keep MPP at machine mode.
  function automatic logic [XLEN-1:0] mstatus_mret(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r = m;
    r[MSTATUS_MIE_BIT] = m[MSTATUS_MPIE_BIT];
    r[MSTATUS_MPIE_BIT] = 1'b1;
    r[MSTATUS_MPP_LSB +: 2] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// CSR-unit side of the trap sequencer: the shared CSR write port plus the
// CSR values and interrupt status the sequencer reads back.
interface trap_sequencer_if;
  import trap_sequencer_pkg::*;

  logic            csr_we_o;
  logic [11:0]     csr_addr_o;
  logic [XLEN-1:0] csr_wdata_o;
  logic [XLEN-1:0] mstatus_i;
  logic [XLEN-1:0] mtvec_i;
  logic [XLEN-1:0] mepc_i;
  logic            irq_pending_i;

  modport master (
    output csr_we_o, csr_addr_o, csr_wdata_o,
    input  mstatus_i, mtvec_i, mepc_i, irq_pending_i
  );

  modport slave (
    input  csr_we_o, csr_addr_o, csr_wdata_o,
    output mstatus_i, mtvec_i, mepc_i, irq_pending_i
  );

endinterface

// File: rtl/trap_sequencer.sv
// Sequences machine-mode trap entry and MRET return through the single CSR
// write port, one CSR write per cycle, ending with a one-cycle PC redirect.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter bit VECTORED_EN = 1'b1,
  parameter bit MTVAL_EN    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exc_req_i,
  input  logic [XLEN-1:0]   exc_cause_i,
  input  logic [XLEN-1:0]   exc_tval_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic              boundary_i,
  input  logic              mret_i,
  trap_sequencer_if.master  csr,
  output logic              stall_o,
  output logic              redirect_o,
  output logic [XLEN-1:0]   redirect_pc_o
);

  trap_state_t     r_state;
  trap_state_t     w_next;
  logic [XLEN-1:0] r_epc;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_tval;
  logic            r_isIrq;
  logic            r_isMret;

  logic            w_takeExc;
  logic            w_takeIrq;
  logic            w_takeMret;
  logic            w_accept;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_vecOff;
  logic            w_unused;

  // The low PC bits never reach MEPC, which is always word aligned.
  assign w_unused = ^pc_i[1:0];

  assign w_base   = {csr.mtvec_i[XLEN-1:2], 2'b00};
  assign w_vecOff = {{(XLEN-7){1'b0}}, r_cause[4:0], 2'b00};
  assign w_accept = w_takeExc | w_takeIrq | w_takeMret;
  assign stall_o  = w_accept | (r_state != IDLE);

  // Next-state and output decode; requests are only looked at in IDLE and
  // are gated by rst_n so every output is zero while reset is held.
  always_comb begin
    w_next          = r_state;
    w_takeExc       = 1'b0;
    w_takeIrq       = 1'b0;
    w_takeMret      = 1'b0;
    csr.csr_we_o    = 1'b0;
    csr.csr_addr_o  = 12'h000;
    csr.csr_wdata_o = '0;
    redirect_o      = 1'b0;
    redirect_pc_o   = '0;
    case (r_state)
      IDLE: begin
        if (rst_n) begin
          if (exc_req_i) begin
            w_takeExc = 1'b1;
            w_next    = SAVE_EPC;
          end else if (csr.irq_pending_i && boundary_i && csr.mstatus_i[MSTATUS_MIE_BIT]) begin
            w_takeIrq = 1'b1;
            w_next    = SAVE_EPC;
          end else if (mret_i) begin
            w_takeMret = 1'b1;
            w_next     = RESTORE_STATUS;
          end
        end
      end
      SAVE_EPC: begin
        csr.csr_we_o    = 1'b1;
        csr.csr_addr_o  = CSR_MEPC;
        csr.csr_wdata_o = {r_epc[XLEN-1:2], 2'b00};
        w_next          = SAVE_CAUSE;
      end
      SAVE_CAUSE: begin
        csr.csr_we_o    = 1'b1;
        csr.csr_addr_o  = CSR_MCAUSE;
        csr.csr_wdata_o = r_cause;
        w_next          = MTVAL_EN ? SAVE_TVAL : SET_STATUS;
      end
      SAVE_TVAL: begin
        csr.csr_we_o    = 1'b1;
        csr.csr_addr_o  = CSR_MTVAL;
        csr.csr_wdata_o = r_tval;
        w_next          = SET_STATUS;
      end
      SET_STATUS: begin
        csr.csr_we_o    = 1'b1;
        csr.csr_addr_o  = CSR_MSTATUS;
        csr.csr_wdata_o = mstatus_trap_entry(csr.mstatus_i);
        w_next          = REDIRECT;
      end
      RESTORE_STATUS: begin
        csr.csr_we_o    = 1'b1;
        csr.csr_addr_o  = CSR_MSTATUS;
        csr.csr_wdata_o = mstatus_mret(csr.mstatus_i);
        w_next          = REDIRECT;
      end
      REDIRECT: begin
        redirect_o = 1'b1;
        if (r_isMret) begin
          redirect_pc_o = csr.mepc_i;
        end else if (VECTORED_EN && r_isIrq && (csr.mtvec_i[1:0] == MTVEC_MODE_VECTORED)) begin
          redirect_pc_o = w_base + w_vecOff;
        end else begin
          redirect_pc_o = w_base;
        end
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State register plus the trap context captured in the accept cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_epc    <= '0;
      r_cause  <= '0;
      r_tval   <= '0;
      r_isIrq  <= 1'b0;
      r_isMret <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_takeExc) begin
        r_epc   <= pc_i;
        r_cause <= exc_cause_i;
        r_tval  <= exc_tval_i;
      end else if (w_takeIrq) begin
        r_epc   <= pc_i;
        r_cause <= M_TIMER_INT;
        r_tval  <= '0;
      end
      if (w_accept) begin
        r_isIrq  <= w_takeIrq;
        r_isMret <= w_takeMret;
      end
    end
  end

  // The controller must hold off new requests while the pipeline is frozen.
  a_noReqWhileBusy: assert property (@(posedge clk) disable iff (!rst_n)
    ((r_state != IDLE) && stall_o) |-> !(exc_req_i || mret_i));

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: trap entry, vectored interrupt, MRET,
// masking, priority, back-to-back traps, MTVAL-less build and mid-trap reset.
module tb_trap_sequencer;

  logic        clk;
  logic        rst_n;
  logic        excReq;
  logic        excReq2;
  logic [31:0] excCause;
  logic [31:0] excTval;
  logic [31:0] pc;
  logic        boundary;
  logic        mret;

  logic        stall1, redir1, stall2, redir2;
  logic [31:0] redirPc1, redirPc2;

  int passCount  = 0;
  int checkCount = 0;

  trap_sequencer_if bus1();
  trap_sequencer_if bus2();

  trap_sequencer #(.VECTORED_EN(1'b1), .MTVAL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .exc_req_i(excReq), .exc_cause_i(excCause),
    .exc_tval_i(excTval), .pc_i(pc), .boundary_i(boundary), .mret_i(mret),
    .csr(bus1), .stall_o(stall1), .redirect_o(redir1), .redirect_pc_o(redirPc1)
  );

  trap_sequencer #(.VECTORED_EN(1'b1), .MTVAL_EN(1'b0)) dutNoTval (
    .clk(clk), .rst_n(rst_n), .exc_req_i(excReq2), .exc_cause_i(excCause),
    .exc_tval_i(excTval), .pc_i(pc), .boundary_i(boundary), .mret_i(1'b0),
    .csr(bus2), .stall_o(stall2), .redirect_o(redir2), .redirect_pc_o(redirPc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkCycle(input string tag, input int which, input logic we,
                            input logic [11:0] addr, input logic [31:0] data,
                            input logic stall, input logic redir, input logic [31:0] rpc);
    logic        oWe, oStall, oRedir;
    logic [11:0] oAddr;
    logic [31:0] oData, oRpc;
    if (which == 1) begin
      oWe = bus1.csr_we_o; oAddr = bus1.csr_addr_o; oData = bus1.csr_wdata_o;
      oStall = stall1; oRedir = redir1; oRpc = redirPc1;
    end else begin
      oWe = bus2.csr_we_o; oAddr = bus2.csr_addr_o; oData = bus2.csr_wdata_o;
      oStall = stall2; oRedir = redir2; oRpc = redirPc2;
    end
    checkOutput({tag, ".we"},     {31'b0, oWe},    {31'b0, we});
    checkOutput({tag, ".addr"},   {20'b0, oAddr},  {20'b0, addr});
    checkOutput({tag, ".wdata"},  oData,           data);
    checkOutput({tag, ".stall"},  {31'b0, oStall}, {31'b0, stall});
    checkOutput({tag, ".redir"},  {31'b0, oRedir}, {31'b0, redir});
    checkOutput({tag, ".rpc"},    oRpc,            rpc);
  endtask

  // Drive one cycle of request inputs at the falling edge; outputs settle 1ns later.
  task automatic applyStimulus(input logic exc, input logic [31:0] cause, input logic [31:0] tval,
                               input logic [31:0] pcv, input logic irq, input logic bnd,
                               input logic mr);
    @(negedge clk);
    excReq   = exc;
    excReq2  = 1'b0;
    excCause = cause;
    excTval  = tval;
    pc       = pcv;
    bus1.irq_pending_i = irq;
    boundary = bnd;
    mret     = mr;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    excReq = 1'b0; excReq2 = 1'b0; excCause = '0; excTval = '0; pc = '0;
    boundary = 1'b0; mret = 1'b0;
    bus1.irq_pending_i = 1'b0; bus1.mstatus_i = '0; bus1.mtvec_i = '0; bus1.mepc_i = '0;
    bus2.irq_pending_i = 1'b0; bus2.mstatus_i = 32'h8; bus2.mtvec_i = 32'h200; bus2.mepc_i = '0;
    #1;
    checkCycle("reset", 1, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Synchronous exception, direct mtvec.
    bus1.mstatus_i = 32'h8; bus1.mtvec_i = 32'h200;
    applyStimulus(1'b1, 32'd2, 32'hDEAD, 32'h100, 1'b0, 1'b0, 1'b0);
    checkCycle("exc.T0", 1, 1'b0, 12'h000, 32'h0,    1'b1, 1'b0, 32'h0);
    idleCycle(); checkCycle("exc.T1", 1, 1'b1, 12'h341, 32'h100,  1'b1, 1'b0, 32'h0);
    idleCycle(); checkCycle("exc.T2", 1, 1'b1, 12'h342, 32'h2,    1'b1, 1'b0, 32'h0);
    idleCycle(); checkCycle("exc.T3", 1, 1'b1, 12'h343, 32'hDEAD, 1'b1, 1'b0, 32'h0);
    idleCycle(); checkCycle("exc.T4", 1, 1'b1, 12'h300, 32'h1880, 1'b1, 1'b0, 32'h0);
    idleCycle(); checkCycle("exc.T5", 1, 1'b0, 12'h000, 32'h0,    1'b1, 1'b1, 32'h200);
    idleCycle(); checkCycle("exc.T6", 1, 1'b0, 12'h000, 32'h0,    1'b0, 1'b0, 32'h0);

    // Timer interrupt with vectored mtvec.
    bus1.mtvec_i = 32'h201;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h40, 1'b1, 1'b1, 1'b0);
    checkCycle("irq.T0", 1, 1'b0, 12'h000, 32'h0,         1'b1, 1'b0, 32'h0);
    idleCycle(); checkCycle("irq.T1", 1, 1'b1, 12'h341, 32'h40,        1'b1, 1'b0, 32'h0);
    idleCycle(); checkCycle("irq.T2", 1, 1'b1, 12'h342, 32'h8000_0007, 1'b1, 1'b0, 32'h0);
    idleCycle(); checkCycle("irq.T3", 1, 1'b1, 12'h343, 32'h0,         1'b1, 1'b0, 32'h0);
    idleCycle(); checkCycle("irq.T4", 1, 1'b1, 12'h300, 32'h1880,      1'b1, 1'b0, 32'h0);
    idleCycle(); checkCycle("irq.T5", 1, 1'b0, 12'h000, 32'h0,         1'b1, 1'b1, 32'h21C);
    idleCycle(); checkCycle("irq.T6", 1, 1'b0, 12'h000, 32'h0,         1'b0, 1'b0, 32'h0);

    // MRET.
    bus1.mstatus_i = 32'h1880; bus1.mepc_i = 32'h104; bus1.mtvec_i = 32'h200;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkCycle("mret.T0", 1, 1'b0, 12'h000, 32'h0,    1'b1, 1'b0, 32'h0);
    idleCycle(); checkCycle("mret.T1", 1, 1'b1, 12'h300, 32'h1888, 1'b1, 1'b0, 32'h0);
    idleCycle(); checkCycle("mret.T2", 1, 1'b0, 12'h000, 32'h0,    1'b1, 1'b1, 32'h104);
    idleCycle(); checkCycle("mret.T3", 1, 1'b0, 12'h000, 32'h0,    1'b0, 1'b0, 32'h0);

    // Interrupt masked by MIE=0, then by no instruction boundary.
    bus1.mstatus_i = 32'h0;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h40, 1'b1, 1'b1, 1'b0);
    checkCycle("maskMie.T0", 1, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0);
    idleCycle(); checkCycle("maskMie.T1", 1, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0);
    bus1.mstatus_i = 32'h8;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h40, 1'b1, 1'b0, 1'b0);
    checkCycle("maskBnd.T0", 1, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0);
    idleCycle(); checkCycle("maskBnd.T1", 1, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0);

    // Exception, interrupt and MRET together: exception wins, not vectored.
    bus1.mtvec_i = 32'h201;
    applyStimulus(1'b1, 32'd11, 32'h55, 32'h302, 1'b1, 1'b1, 1'b1);
    checkCycle("prio.T0", 1, 1'b0, 12'h000, 32'h0,    1'b1, 1'b0, 32'h0);
    idleCycle(); checkCycle("prio.T1", 1, 1'b1, 12'h341, 32'h300,  1'b1, 1'b0, 32'h0);
    idleCycle(); checkCycle("prio.T2", 1, 1'b1, 12'h342, 32'd11,   1'b1, 1'b0, 32'h0);
    idleCycle(); checkCycle("prio.T3", 1, 1'b1, 12'h343, 32'h55,   1'b1, 1'b0, 32'h0);
    idleCycle(); checkCycle("prio.T4", 1, 1'b1, 12'h300, 32'h1880, 1'b1, 1'b0, 32'h0);
    idleCycle(); checkCycle("prio.T5", 1, 1'b0, 12'h000, 32'h0,    1'b1, 1'b1, 32'h200);

    // Back-to-back exception accepted right after REDIRECT.
    applyStimulus(1'b1, 32'd5, 32'h0, 32'h500, 1'b0, 1'b0, 1'b0);
    checkCycle("b2b.T0", 1, 1'b0, 12'h000, 32'h0,   1'b1, 1'b0, 32'h0);
    idleCycle(); checkCycle("b2b.T1", 1, 1'b1, 12'h341, 32'h500, 1'b1, 1'b0, 32'h0);
    idleCycle(); checkCycle("b2b.T2", 1, 1'b1, 12'h342, 32'd5,   1'b1, 1'b0, 32'h0);
    idleCycle(); idleCycle(); idleCycle();
    checkCycle("b2b.T5", 1, 1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 32'h200);
    idleCycle(); checkCycle("b2b.T6", 1, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0);

    // Build without MTVAL: the MTVAL write is skipped.
    @(negedge clk);
    excReq2 = 1'b1; excCause = 32'd2; excTval = 32'hDEAD; pc = 32'h100;
    #1;
    checkCycle("noTval.T0", 2, 1'b0, 12'h000, 32'h0,    1'b1, 1'b0, 32'h0);
    idleCycle(); checkCycle("noTval.T1", 2, 1'b1, 12'h341, 32'h100,  1'b1, 1'b0, 32'h0);
    idleCycle(); checkCycle("noTval.T2", 2, 1'b1, 12'h342, 32'h2,    1'b1, 1'b0, 32'h0);
    idleCycle(); checkCycle("noTval.T3", 2, 1'b1, 12'h300, 32'h1880, 1'b1, 1'b0, 32'h0);
    idleCycle(); checkCycle("noTval.T4", 2, 1'b0, 12'h000, 32'h0,    1'b1, 1'b1, 32'h200);
    idleCycle(); checkCycle("noTval.T5", 2, 1'b0, 12'h000, 32'h0,    1'b0, 1'b0, 32'h0);

    // Reset in the middle of a trap, then a fresh exception.
    bus1.mstatus_i = 32'h8; bus1.mtvec_i = 32'h200;
    applyStimulus(1'b1, 32'd2, 32'hDEAD, 32'h100, 1'b0, 1'b0, 1'b0);
    idleCycle();
    idleCycle(); checkCycle("rst.T2", 1, 1'b1, 12'h342, 32'h2, 1'b1, 1'b0, 32'h0);
    rst_n = 1'b0; excReq = 1'b1;
    #1;
    checkCycle("rst.held", 1, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; excReq = 1'b0;
    #1;
    checkCycle("rst.release", 1, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'd3, 32'h12, 32'h80, 1'b0, 1'b0, 1'b0);
    checkCycle("post.T0", 1, 1'b0, 12'h000, 32'h0,    1'b1, 1'b0, 32'h0);
    idleCycle(); checkCycle("post.T1", 1, 1'b1, 12'h341, 32'h80,   1'b1, 1'b0, 32'h0);
    idleCycle(); checkCycle("post.T2", 1, 1'b1, 12'h342, 32'd3,    1'b1, 1'b0, 32'h0);
    idleCycle(); checkCycle("post.T3", 1, 1'b1, 12'h343, 32'h12,   1'b1, 1'b0, 32'h0);
    idleCycle(); checkCycle("post.T4", 1, 1'b1, 12'h300, 32'h1880, 1'b1, 1'b0, 32'h0);
    idleCycle(); checkCycle("post.T5", 1, 1'b0, 12'h000, 32'h0,    1'b1, 1'b1, 32'h200);
    idleCycle(); checkCycle("post.T6", 1, 1'b0, 12'h000, 32'h0,    1'b0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
